// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 fetch-stage program counter.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package mips_pkg;

  // Source selected for the next fetch address.
  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JREG   = 2'd2,
    JIMM   = 2'd3
  } npc_src_t;

  localparam int          DEF_ADDR_W       = 32;
  localparam int          DEF_JIMM_W       = 26;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0;

  // Conditional branch resolution from the decoded branch type and ALU zero flag.
  function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
    return (beq & zero) | (bne & ~zero);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count; a push while full overwrites the oldest entry.
// Latency: push/pop take effect on the next clock edge; top is combinational from current state.
// Backpressure: none; the caller gates push/pop (e.g. with stall), pop while empty is ignored.
import mips_pkg::*;

module ras_stack #(
  parameter int W     = DEF_ADDR_W,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ras_stack: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;       // next free slot; oldest entry when full
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  assign top_ptr = ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;

  // Entry storage: a push with a simultaneous pop replaces the top in place.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[do_pop ? top_ptr : ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; the pointer wraps naturally so a full push discards the oldest.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) begin
        count <= count + CNT_W'(1);
      end
    end else if (do_pop) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter: next-pc mux (branch > jr > j/jal > sequential), redirect flag, RAS for jal / jr $ra.
// Latency: one cycle from decode inputs to the new pc; pc_plus is combinational from pc.
// Backpressure: stall holds pc, redirect and RAS; PC_PERF_EN adds perf_redirects / perf_stalls counters.
import mips_pkg::*;

module pc_sequencer #(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                INC          = 1,
  parameter int                OFF_SHIFT    = 0,
  parameter int                JIMM_W       = DEF_JIMM_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              beq,
  input  logic              bne,
  input  logic              zero,
  input  logic              j,
  input  logic              jal,
  input  logic              jr,
  input  logic              jr_use_ras,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic [ADDR_W-1:0] jump_addr_reg,
  input  logic [JIMM_W-1:0] jump_imm,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              redirect,
  output logic              ras_empty,
`ifdef PC_PERF_EN
  output logic              ras_full,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_stalls
`else
  output logic              ras_full
`endif
);

  if (OFF_SHIFT != $clog2(INC)) begin : g_bad_shift
    $error("pc_sequencer: OFF_SHIFT must equal log2(INC)");
  end
  if ((INC < 1) || ((INC & (INC - 1)) != 0)) begin : g_bad_inc
    $error("pc_sequencer: INC must be a power of two");
  end

  // Bits of pc replaced by the jump immediate and its alignment zeros.
  localparam int                JLOW      = JIMM_W + OFF_SHIFT;
  localparam logic [ADDR_W-1:0] JLOW_MASK = (JLOW >= ADDR_W) ? {ADDR_W{1'b1}}
                                          : ((ADDR_W'(1) << JLOW) - ADDR_W'(1));

  npc_src_t          sel;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jimm_target;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push;
  logic              ras_pop;

  assign pc_plus       = pc + ADDR_W'(INC);
  assign branch_target = pc_plus + (branch_off << OFF_SHIFT);
  assign jimm_target   = (pc & ~JLOW_MASK) | (ADDR_W'(jump_imm) << OFF_SHIFT);

  // Prioritised next-pc selection.
  always_comb begin
    sel     = SEQ;
    next_pc = pc_plus;
    if (branch_taken(beq, bne, zero)) begin
      sel     = BRANCH;
      next_pc = branch_target;
    end else if (jr) begin
      sel     = JREG;
      next_pc = (jr_use_ras && !ras_empty) ? ras_top : jump_addr_reg;
    end else if (j || jal) begin
      sel     = JIMM;
      next_pc = jimm_target;
    end
  end

  // jal links whenever a jump wins (including jalr); a taken branch suppresses the link.
  assign ras_push = ~stall & jal & ((sel == JREG) || (sel == JIMM));
  assign ras_pop  = ~stall & (sel == JREG) & jr_use_ras & ~ras_empty;

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // pc and redirect registers; both hold across a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      redirect <= 1'b0;
    end else if (!stall) begin
      pc       <= next_pc;
      redirect <= (sel != SEQ);
    end
  end

`ifdef PC_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_redirects <= '0;
      perf_stalls    <= '0;
    end else begin
      if (stall) begin
        perf_stalls <= perf_stalls + 32'd1;
      end else if (sel != SEQ) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (word-addressed instance plus a byte-addressed instance).
// Latency: checks the registered pc one clock after each vector is applied.
// Backpressure: exercises stall holding pc/redirect/RAS and reset taking priority over stall.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset, stall, beq, bne, zero, j, jal, jr, jr_use_ras;
  logic [31:0] branch_off, jump_addr_reg;
  logic [25:0] jump_imm;

  logic [31:0] pc, pc_plus;
  logic        redirect, ras_empty, ras_full;
  logic [31:0] pc4, pc_plus4;
  logic        redirect4, ras_empty4, ras_full4;
`ifdef PC_PERF_EN
  logic [31:0] perf_redirects, perf_stalls, perf_redirects4, perf_stalls4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall), .beq(beq), .bne(bne), .zero(zero),
    .j(j), .jal(jal), .jr(jr), .jr_use_ras(jr_use_ras), .branch_off(branch_off),
    .jump_addr_reg(jump_addr_reg), .jump_imm(jump_imm), .pc(pc), .pc_plus(pc_plus),
    .redirect(redirect), .ras_empty(ras_empty),
`ifdef PC_PERF_EN
    .perf_redirects(perf_redirects), .perf_stalls(perf_stalls),
`endif
    .ras_full(ras_full)
  );

  pc_sequencer #(.ADDR_W(32), .INC(4), .OFF_SHIFT(2), .RESET_VECTOR(32'h100)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .beq(beq), .bne(bne), .zero(zero),
    .j(j), .jal(jal), .jr(jr), .jr_use_ras(jr_use_ras), .branch_off(branch_off),
    .jump_addr_reg(jump_addr_reg), .jump_imm(jump_imm), .pc(pc4), .pc_plus(pc_plus4),
    .redirect(redirect4), .ras_empty(ras_empty4),
`ifdef PC_PERF_EN
    .perf_redirects(perf_redirects4), .perf_stalls(perf_stalls4),
`endif
    .ras_full(ras_full4)
  );

  // Control bit positions for the vector table.
  localparam int C_R   = 256;
  localparam int C_S   = 128;
  localparam int C_BEQ = 64;
  localparam int C_BNE = 32;
  localparam int C_Z   = 16;
  localparam int C_J   = 8;
  localparam int C_JAL = 4;
  localparam int C_JR  = 2;
  localparam int C_RAS = 1;

  typedef struct {
    string       nm;
    logic [8:0]  ctl;
    logic [31:0] off;
    logic [31:0] jaddr;
    logic [25:0] imm;
    logic [31:0] exp_pc;
    logic        exp_rd;
    logic        exp_empty;
    logic        exp_full;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, int ctl, logic [31:0] off, logic [31:0] jaddr,
                              logic [25:0] imm, logic [31:0] exp_pc, logic exp_rd,
                              logic exp_empty, logic exp_full);
    vec_t v;
    v.nm = nm; v.ctl = 9'(ctl); v.off = off; v.jaddr = jaddr; v.imm = imm;
    v.exp_pc = exp_pc; v.exp_rd = exp_rd; v.exp_empty = exp_empty; v.exp_full = exp_full;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [8:0] ctl, logic [31:0] off, logic [31:0] jaddr, logic [25:0] imm);
    reset      = ctl[8];
    stall      = ctl[7];
    beq        = ctl[6];
    bne        = ctl[5];
    zero       = ctl[4];
    j          = ctl[3];
    jal        = ctl[2];
    jr         = ctl[1];
    jr_use_ras = ctl[0];
    branch_off = off;
    jump_addr_reg = jaddr;
    jump_imm   = imm;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(9'(C_R), 32'h0, 32'h0, 26'h0);
    step();
    step();
    chk("reset pc", pc, 32'h0);
    chk("reset pc_plus", pc_plus, 32'h1);
    chk("reset redirect", {31'b0, redirect}, 32'h0);
    chk("reset ras_empty", {31'b0, ras_empty}, 32'h1);
    chk("reset ras_full", {31'b0, ras_full}, 32'h0);

    // Word-addressed instance: applied vector, then expected state after the edge.
    vecs.push_back(mk("seq1", 0, 0, 0, 0, 32'h1, 0, 1, 0));
    vecs.push_back(mk("seq2", 0, 0, 0, 0, 32'h2, 0, 1, 0));
    vecs.push_back(mk("seq3", 0, 0, 0, 0, 32'h3, 0, 1, 0));
    vecs.push_back(mk("jr10", C_JR, 0, 32'd10, 0, 32'd10, 1, 1, 0));
    vecs.push_back(mk("beq_taken", C_BEQ|C_Z, -32'sd4, 0, 0, 32'd7, 1, 1, 0));
    vecs.push_back(mk("jr10b", C_JR, 0, 32'd10, 0, 32'd10, 1, 1, 0));
    vecs.push_back(mk("bne_not_taken", C_BNE|C_Z, -32'sd4, 0, 0, 32'd11, 0, 1, 0));
    vecs.push_back(mk("jr40", C_JR, 0, 32'h40, 0, 32'h40, 1, 1, 0));
    vecs.push_back(mk("jal100", C_JAL, 0, 0, 26'h100, 32'h100, 1, 0, 0));
    vecs.push_back(mk("jr_ras_pop", C_JR|C_RAS, 0, 32'h999, 0, 32'h41, 1, 1, 0));
    vecs.push_back(mk("push1", C_JAL, 0, 0, 26'h200, 32'h200, 1, 0, 0));
    vecs.push_back(mk("push2", C_JAL, 0, 0, 26'h300, 32'h300, 1, 0, 0));
    vecs.push_back(mk("push3", C_JAL, 0, 0, 26'h400, 32'h400, 1, 0, 0));
    vecs.push_back(mk("push4_full", C_JAL, 0, 0, 26'h500, 32'h500, 1, 0, 1));
    vecs.push_back(mk("push5_overwrite", C_JAL, 0, 0, 26'h600, 32'h600, 1, 0, 1));
    vecs.push_back(mk("pop1", C_JR|C_RAS, 0, 32'h999, 0, 32'h501, 1, 0, 0));
    vecs.push_back(mk("pop2", C_JR|C_RAS, 0, 32'h999, 0, 32'h401, 1, 0, 0));
    vecs.push_back(mk("pop3", C_JR|C_RAS, 0, 32'h999, 0, 32'h301, 1, 0, 0));
    vecs.push_back(mk("pop4", C_JR|C_RAS, 0, 32'h999, 0, 32'h201, 1, 1, 0));
    vecs.push_back(mk("pop_empty_fallback", C_JR|C_RAS, 0, 32'h999, 0, 32'h999, 1, 1, 0));
    vecs.push_back(mk("j_low", C_J, 0, 0, 26'h5, 32'h5, 1, 1, 0));
    vecs.push_back(mk("jr_high", C_JR, 0, 32'hFC000010, 0, 32'hFC000010, 1, 1, 0));
    vecs.push_back(mk("j_keep_upper", C_J, 0, 0, 26'h3, 32'hFC000003, 1, 1, 0));
    vecs.push_back(mk("branch_beats_jal", C_BEQ|C_Z|C_JAL, 32'd2, 0, 26'h77, 32'hFC000006, 1, 1, 0));
    vecs.push_back(mk("jal_push", C_JAL, 0, 0, 26'h10, 32'hFC000010, 1, 0, 0));
    vecs.push_back(mk("push_pop_same", C_JR|C_RAS|C_JAL, 0, 32'h999, 0, 32'hFC000007, 1, 0, 0));
    vecs.push_back(mk("pop_replaced_top", C_JR|C_RAS, 0, 32'h999, 0, 32'hFC000011, 1, 1, 0));
    vecs.push_back(mk("jalr_reg", C_JR|C_JAL, 0, 32'h20, 0, 32'h20, 1, 0, 0));
    vecs.push_back(mk("pop_jalr_link", C_JR|C_RAS, 0, 32'h999, 0, 32'hFC000012, 1, 1, 0));
    vecs.push_back(mk("seq_after", 0, 0, 0, 0, 32'hFC000013, 0, 1, 0));
    vecs.push_back(mk("stall1", C_S|C_JAL, 0, 0, 26'h123, 32'hFC000013, 0, 1, 0));
    vecs.push_back(mk("stall2", C_S|C_JAL, 0, 0, 26'h123, 32'hFC000013, 0, 1, 0));
    vecs.push_back(mk("stall3", C_S|C_JAL, 0, 0, 26'h123, 32'hFC000013, 0, 1, 0));
    vecs.push_back(mk("no_push_in_stall", C_JR|C_RAS, 0, 32'h30, 0, 32'h30, 1, 1, 0));
    vecs.push_back(mk("jal50", C_JAL, 0, 0, 26'h50, 32'h50, 1, 0, 0));
    vecs.push_back(mk("stall_hold_rd", C_S|C_JAL, 0, 0, 26'h77, 32'h50, 1, 0, 0));
    vecs.push_back(mk("reset_in_stall", C_R|C_S|C_JAL, 0, 0, 26'h77, 32'h0, 0, 1, 0));
    vecs.push_back(mk("seq_after_reset", 0, 0, 0, 0, 32'h1, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].off, vecs[i].jaddr, vecs[i].imm);
      step();
      chk({vecs[i].nm, " pc"}, pc, vecs[i].exp_pc);
      chk({vecs[i].nm, " pc_plus"}, pc_plus, vecs[i].exp_pc + 32'd1);
      chk({vecs[i].nm, " redirect"}, {31'b0, redirect}, {31'b0, vecs[i].exp_rd});
      chk({vecs[i].nm, " ras_empty"}, {31'b0, ras_empty}, {31'b0, vecs[i].exp_empty});
      chk({vecs[i].nm, " ras_full"}, {31'b0, ras_full}, {31'b0, vecs[i].exp_full});
    end

    // Byte-addressed instance: shifted branch offset, wrap at the top of memory, aligned jump.
    drive(9'(C_R), 0, 0, 0);
    step();
    chk("inc4 reset pc", pc4, 32'h100);
    chk("inc4 reset pc_plus", pc_plus4, 32'h104);
    chk("inc4 reset ras_empty", {31'b0, ras_empty4}, 32'h1);
    drive(9'(C_BEQ|C_Z), 32'd3, 0, 0);
    step();
    chk("inc4 branch pc", pc4, 32'h110);
    chk("inc4 branch redirect", {31'b0, redirect4}, 32'h1);
    drive(9'(C_JR), 0, 32'hFFFFFFFC, 0);
    step();
    chk("inc4 top pc", pc4, 32'hFFFFFFFC);
    chk("inc4 top pc_plus wraps", pc_plus4, 32'h0);
    drive(9'(0), 0, 0, 0);
    step();
    chk("inc4 wrap pc", pc4, 32'h0);
    chk("inc4 wrap redirect", {31'b0, redirect4}, 32'h0);
    drive(9'(C_J), 0, 0, 26'h40);
    step();
    chk("inc4 j aligned pc", pc4, 32'h100);
    drive(9'(C_JAL), 0, 0, 26'h80);
    step();
    chk("inc4 jal pc", pc4, 32'h200);
    drive(9'(C_JR|C_RAS), 0, 32'h999, 0);
    step();
    chk("inc4 ras return", pc4, 32'h104);
    chk("inc4 ras empty after pop", {31'b0, ras_empty4}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the MIPS32 fetch stage.
- Generalised address width and word/byte addressing.
- Adds a fetch stall, an explicit redirect indication and a hardware return-address stack (RAS) for jal / jr $ra.
- Drives the instruction-memory address; consumes branch and jump decode from the control unit and ALU zero flag.

Parameters:
ADDR_W, 32, width of pc and all address ports
INC, 1, sequential increment (1 = word-addressed imem, 4 = byte-addressed)
OFF_SHIFT, 0, left shift applied to branch offset and jump immediate (0 word, 2 byte); must equal log2(INC)
JIMM_W, 26, width of jump immediate field
RESET_VECTOR, 0, pc value after reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold pc and RAS this cycle
beq  in  1  branch-if-equal decoded
bne  in  1  branch-if-not-equal decoded
zero  in  1  ALU zero flag
j  in  1  jump decoded
jal  in  1  jump-and-link decoded
jr  in  1  jump-register decoded
jr_use_ras  in  1  jr targets $ra; use RAS top when non-empty
branch_off  in  ADDR_W  sign-extended branch offset (unshifted)
jump_addr_reg  in  ADDR_W  register jump target
jump_imm  in  JIMM_W  jump immediate
pc  out  ADDR_W  current fetch address
pc_plus  out  ADDR_W  pc + INC (combinational)
redirect  out  1  registered; 1 when the current pc came from a non-sequential update
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (synchronous, highest priority): pc = RESET_VECTOR, redirect = 0, RAS count = 0, RAS pointer = 0, ras_empty = 1, ras_full = 0. Applies mid-stall and mid-operation; RAS contents become don't-care.
- stall = 1 and no reset: pc, redirect, RAS state and counters all hold. Decode inputs are ignored.
- Next-pc priority when not stalled:
  1. taken branch ((beq & zero) | (bne & ~zero)): pc_plus + (branch_off << OFF_SHIFT)
  2. jr: RAS top if jr_use_ras & ~ras_empty, else jump_addr_reg
  3. j | jal: {pc[ADDR_W-1 : JIMM_W+OFF_SHIFT], jump_imm, OFF_SHIFT zero bits}
  4. otherwise pc_plus
- Arithmetic: modulo 2^ADDR_W; pc wraps from max to 0 silently.
- redirect <= 1 when priority 1–3 is selected, else 0. Single-cycle latency: the new pc is visible the cycle after the decode inputs.
- RAS push: pc_plus is pushed when jal is asserted and priority 2 or 3 wins (jr + jal = jalr semantics, push still occurs). No push when a taken branch wins.
- Push when full: overwrite the oldest entry (circular); count stays at RAS_DEPTH.
- RAS pop: only when jr & jr_use_ras & ~ras_empty and jr is selected; count decrements. Pop when empty: no state change, jump_addr_reg is used.
- Simultaneous push and pop (jr & jr_use_ras & jal): read the old top as the target, then replace the top with pc_plus; count unchanged.
- Behaviour with OFF_SHIFT != log2(INC) is unsupported; flag it with an elaboration-time check.

Optional Feature:
PC_PERF_EN
- Defined: adds 32-bit outputs perf_redirects and perf_stalls.
  - perf_redirects increments on each non-stalled redirect.
  - perf_stalls increments on each cycle with stall = 1.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg: next-pc source enum (SEQ, BRANCH, JREG, JIMM), default ADDR_W, JIMM_W, RESET_VECTOR.
- One sub-module, ras_stack: circular stack with count, push/pop/simultaneous handling, empty/full flags. pc_sequencer holds only the pc register, next-pc mux and redirect logic.

Test Plan:
- Reset then 3 free-running cycles (INC=1): pc = 0,1,2,3; redirect = 0 throughout.
- pc=10, beq=1, zero=1, branch_off=-4 -> pc=7, redirect=1. Repeat with bne=1, zero=1 -> pc=11, redirect=0.
- pc=0x40, jal=1, jump_imm=0x100 -> pc=0x100, RAS holds 0x41. Then jr=1, jr_use_ras=1, jump_addr_reg=0x999 -> pc=0x41, ras_empty=1.
- 5 jal pushes with RAS_DEPTH=4 -> ras_full=1. 4 RAS pops return the last 4 pushed addresses in reverse order; the 5th pop falls back to jump_addr_reg.
- stall=1 for 3 cycles while jal=1 -> pc, RAS count and redirect unchanged. Assert reset during the stall -> pc=RESET_VECTOR, ras_empty=1 next cycle.
- INC=4, OFF_SHIFT=2: pc=0x100, branch taken, branch_off=3 -> pc=0x110. pc=0xFFFFFFFC sequential -> pc=0 (wrap).
